// File: rtl/div_axis_iter_if.sv
// rtl/div_axis_iter_if.sv - operand and result stream bundle for div_axis_iter
interface div_axis_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tvalid;
    logic               s_axis_dividend_tready;
    logic [WIDTH-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tvalid;
    logic               s_axis_divisor_tready;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;
    logic               m_axis_dout_tvalid;

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tdata, m_axis_dout_tvalid
    );

    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tdata, m_axis_dout_tvalid
    );
endinterface

// File: rtl/div_axis_iter.sv
// rtl/div_axis_iter.sv - iterative radix-2 restoring divider with stream operands
// Optional macro DIV_EARLY_FINISH_EN: skip iteration when |a| < |b| and b != 0.
module div_axis_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    div_axis_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  dvd_q, dvs_q;
    logic              dvd_full, dvs_full;
    logic              dvd_hs, dvs_hs, start, early;
    logic [WIDTH-1:0]  op_a, op_b, a_mag, b_mag;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  mag_b, quo, rem;
    logic              sq, sr, b_zero;
    logic [CW-1:0]     cnt;
    logic [WIDTH:0]    r_shift, diff;
    logic [WIDTH-1:0]  q_fin, r_fin;

    assign bus.s_axis_dividend_tready = (state == IDLE) & ~dvd_full;
    assign bus.s_axis_divisor_tready  = (state == IDLE) & ~dvs_full;

    assign dvd_hs = bus.s_axis_dividend_tvalid & bus.s_axis_dividend_tready;
    assign dvs_hs = bus.s_axis_divisor_tvalid & bus.s_axis_divisor_tready;

    // An operand arriving on the start edge is used straight off the bus.
    assign op_a  = dvd_full ? dvd_q : bus.s_axis_dividend_tdata;
    assign op_b  = dvs_full ? dvs_q : bus.s_axis_divisor_tdata;
    assign start = (state == IDLE) & (dvd_full | dvd_hs) & (dvs_full | dvs_hs);

    assign a_neg = SIGNED & op_a[WIDTH-1];
    assign b_neg = SIGNED & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

`ifdef DIV_EARLY_FINISH_EN
    assign early = (b_mag != '0) && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // quo starts as |a| and is shifted out MSB-first while quotient bits shift in.
    assign r_shift = {rem, quo[WIDTH-1]};
    assign diff    = r_shift - {1'b0, mag_b};

    assign q_fin = b_zero ? '1 : (sq ? -quo : quo);
    assign r_fin = sr ? -rem : rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = early ? FIX : CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dvd_q                  <= '0;
            dvs_q                  <= '0;
            dvd_full               <= 1'b0;
            dvs_full               <= 1'b0;
            mag_b                  <= '0;
            quo                    <= '0;
            rem                    <= '0;
            sq                     <= 1'b0;
            sr                     <= 1'b0;
            b_zero                 <= 1'b0;
            cnt                    <= '0;
            bus.m_axis_dout_tdata  <= '0;
            bus.m_axis_dout_tvalid <= 1'b0;
        end else begin
            bus.m_axis_dout_tvalid <= 1'b0;
            if (dvd_hs) begin
                dvd_q    <= bus.s_axis_dividend_tdata;
                dvd_full <= 1'b1;
            end
            if (dvs_hs) begin
                dvs_q    <= bus.s_axis_divisor_tdata;
                dvs_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_b  <= b_mag;
                        sq     <= a_neg ^ b_neg;
                        sr     <= a_neg;
                        b_zero <= (op_b == '0);
                        cnt    <= '0;
                        if (early) begin
                            quo <= '0;
                            rem <= a_mag;
                        end else begin
                            quo <= a_mag;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= r_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    bus.m_axis_dout_tdata  <= {q_fin, r_fin};
                    bus.m_axis_dout_tvalid <= 1'b1;
                    dvd_full               <= 1'b0;
                    dvs_full               <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/div_axis_iter.md
# div_axis_iter

Iterative radix-2 restoring divider acting as the responder on the EX stage's dividend/divisor stream handshake. It replaces the vendor divider IP behind `div.w`, `mod.w`, `div.wu` and `mod.wu`. It accepts the two operands on independent valid/ready channels and computes quotient and remainder over `WIDTH` iteration cycles. It returns both in one `dout` beat that is a single-cycle pulse with no back-pressure. The pipeline instantiates one copy with `SIGNED=1` and one with `SIGNED=0`.

## Interface
- `WIDTH`, default 32: operand width.
- `SIGNED`, default 1: 1 = two's-complement operands; 0 = unsigned operands.
- Clock is `clk`. Reset is `resetn`, synchronous, active-low.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `s_axis_dividend_tdata`  in  WIDTH  dividend.
- `s_axis_dividend_tvalid`  in  1  dividend offered.
- `s_axis_dividend_tready`  out  1  dividend slot empty and core idle.
- `s_axis_divisor_tdata`  in  WIDTH  divisor.
- `s_axis_divisor_tvalid`  in  1  divisor offered.
- `s_axis_divisor_tready`  out  1  divisor slot empty and core idle.
- `m_axis_dout_tdata`  out  2*WIDTH  {quotient, remainder}: quotient in the high half, remainder in the low half.
- `m_axis_dout_tvalid`  out  1  one-cycle result strobe.

## Operation
- **Holding slots.** Each channel has one holding register and a full flag.
  - A channel handshakes when tvalid & tready at a clock edge; tdata is captured at that edge.
  - tready = state IDLE & ~slot_full.
  - The two channels complete independently, in either order or at the same edge.
- **IDLE.** When both slots are full, or one is full and the other handshakes this edge, the block moves to CALC at the edge where the last operand is captured (the start edge).
  - At the start edge it latches the magnitudes |a| and |b|; for `SIGNED=0` these are the raw values.
  - It latches the signs sq = sa^sb and sr = sa.
  - It clears the partial remainder and the iteration counter.
- **CALC.** Each edge shifts the next dividend bit (MSB first) into the WIDTH+1-bit partial remainder.
  - It subtracts |b| if the result is non-negative and shifts the quotient bit in.
  - After exactly WIDTH iteration edges the block goes to FIX. The counter runs 0..WIDTH-1.
- **FIX.** One edge. It applies the signs: quotient is negated if sq, remainder is negated if sr. It registers `m_axis_dout_tdata`, pulses `m_axis_dout_tvalid`, clears both slot_full flags and returns to IDLE.
- **Divide by zero** (b == 0), both modes: quotient = all ones, remainder = dividend. The iteration is still run, so latency is unchanged.
- **Signed overflow** (`SIGNED=1`, a = 0x8000_0000, b = -1): quotient = 0x8000_0000, remainder = 0.
- **Sign rules.** The quotient truncates toward zero. The remainder takes the sign of the dividend.
- **Outputs.** `m_axis_dout_tdata` holds its value until the next FIX. There is no output ready; the consumer must sample in the strobe cycle.
- **Reset.** Reset, including mid-CALC, clears state to IDLE, both slot_full flags, the counter, `m_axis_dout_tvalid`=0 and `m_axis_dout_tdata`=0. No strobe is issued for an aborted operation.
- **Reset values.** Both treadys read 1 after reset. `m_axis_dout_tvalid`=0. `m_axis_dout_tdata`=0.

## Timing
- **Latency.** Start edge E0, iterations E1..E_WIDTH, FIX at E_(WIDTH+1). `m_axis_dout_tvalid` is high for exactly the cycle after E_(WIDTH+1), which is 33 edges for WIDTH=32.
- **treadys.** A channel's tready drops in the cycle after its handshake and stays low through CALC and FIX. Both are high again in the same cycle as the dout strobe, so back-to-back operations have a gap of 0 idle cycles.
- **Offers while busy.** tvalid held while busy is not consumed, and no data is lost.
- **Early operand.** If one operand arrives early, its slot stays full and its tready stays low until the operation completes.

## Configuration
- **`DIV_EARLY_FINISH_EN` defined.** If at the start edge b != 0 and |a| < |b|, the block skips CALC and goes directly to FIX with quotient 0 and remainder = a.
  - Strobe is in the cycle after E1.
  - All other cases are unchanged.
- **`DIV_EARLY_FINISH_EN` undefined.** Latency is always WIDTH+1 edges.

## Test plan
- `SIGNED=1`, dividend -7 and divisor 2 at the same edge -> one strobe 33 edges later, tdata = {0xFFFF_FFFD, 0xFFFF_FFFF}.
- `SIGNED=0`, 0xFFFF_FFFF / 0x10 -> {0x0FFF_FFFF, 0x0000_000F}. Divisor offered 3 cycles after dividend: dividend tready low during the gap, latency counted from the divisor edge.
- Divide by zero in both modes: 0x1234 / 0 -> {0xFFFF_FFFF, 0x0000_1234}. `SIGNED=1`, 0x8000_0000 / -1 -> {0x8000_0000, 0}.
- Assert resetn=0 at iteration 10, then release and issue 9 / 3 -> no strobe for the aborted operation, then exactly one strobe with {3, 0}, 33 edges after acceptance.
- Back-to-back: new operands held valid throughout, accepted in the strobe cycle -> second strobe exactly 33 edges later. The first tdata stays stable until then.
- With `DIV_EARLY_FINISH_EN`, 5 / 9 -> {0, 5}, strobe in the cycle after E1; 9 / 5 -> full latency, {1, 4}.
